bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 1, giving the count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 500_000, giving the button stable-time in clk cycles (10 ms at 50 MHz).
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low, one clock domain only.
REQ-006 btn_start  in  1  raw asynchronous push button; a press toggles run/pause.
REQ-007 btn_clear  in  1  raw asynchronous push button; a press returns the counter to zero and idle.
REQ-008 up_down  in  1  count direction, 1 = up, 0 = down, sampled at each tick.
REQ-009 load  in  1  synchronous level strobe that captures load_value.
REQ-010 load_value  in  16  four BCD nibbles, [3:0] least significant.
REQ-011 digit1..digit4  out  4 each  BCD count, digit1 least significant; these feed the display controller digit inputs directly.
REQ-012 running  out  1  high while in RUN.
REQ-013 wrap  out  1  one-cycle pulse on each 9999->0000 or 0000->9999 transition.

Function
REQ-014 Each button SHALL pass through a two-flop synchronizer, then a debouncer, then a rising-edge detector that produces a one-cycle press pulse.
REQ-015 Debouncer: the stable output SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the counter.
REQ-016 Press latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles from the input edge to the press pulse; a release SHALL never produce a pulse.
REQ-017 FSM states SHALL be IDLE, RUN and PAUSE, encoded in 2 bits with the fourth code recovering to IDLE.
REQ-018 IDLE -> RUN on a start press; RUN -> PAUSE on a start press; PAUSE -> RUN on a start press.
REQ-019 A clear press in any state SHALL force IDLE, set all digits to 0 and zero the prescaler on the next edge.
REQ-020 Prescaler: counts 0..CLK_HZ/TICK_HZ-1 only in RUN; emits a one-cycle tick on the terminal count and then wraps to 0; holds its value in PAUSE; zeroed in IDLE.
REQ-021 On a tick with up_down=1, the count SHALL increment as decimal with ripple carry: a nibble at 9 becomes 0 and carries into the next digit.
REQ-022 On a tick with up_down=0, the count SHALL decrement as decimal with borrow: a nibble at 0 becomes 9 and borrows from the next digit.
REQ-023 Up from 9999 SHALL give 0000, and down from 0000 SHALL give 9999; wrap SHALL be high in the same cycle the digits update.
REQ-024 load=1 in IDLE or PAUSE SHALL copy load_value into the digits on the next edge, with any nibble above 9 clamped to 9; load SHALL be ignored in RUN.
REQ-025 Simultaneous clear and start presses: clear wins, and the result is IDLE with zero digits.
REQ-026 Clear and tick in the same cycle: clear wins, with no increment and no wrap.
REQ-027 Load and start press in the same cycle (IDLE or PAUSE): the loaded value is taken, the FSM enters RUN and the prescaler starts from 0.
REQ-028 up_down changes SHALL take effect on the next tick only, with no glitch on the digits.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst_n=0: state IDLE; digits 0; running 0; wrap 0; prescaler 0; all debouncer counters 0; synchronizer and debounced levels 0.
REQ-031 Reset asserted mid-count or mid-debounce SHALL abandon the operation immediately, and no press pulse or tick SHALL follow deassertion.
REQ-032 After rst_n rises, a button already held high SHALL produce exactly one press once debounced.

Verification (CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4)
REQ-033 Start pressed and held -> press pulse 6 cycles after the edge, running=1, and the first increment 10 cycles later, giving digits 0001.
REQ-034 Button bouncing 1-0-1 with 2-cycle gaps, then held -> exactly one press, with timing measured from the final rising edge.
REQ-035 Load 0x9999 in IDLE, start, up_down=1 -> after 1 tick digits 0000 and wrap=1 for exactly one cycle; load 0x0000 with down counting -> 9999 and wrap=1.
REQ-036 load_value 0xA3F1 in PAUSE -> digits 9,3,9,1 (digit4..digit1); load asserted during RUN -> digits unchanged.
REQ-037 Clear press in the same cycle as a tick in RUN -> digits 0000, wrap=0, state IDLE.
REQ-038 Pause at prescaler=7, resume -> next tick 3 cycles after re-entering RUN; rst_n pulsed mid-RUN -> all outputs 0 and IDLE.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - four-digit BCD up/down stopwatch counter with debounced start/clear buttons
module bcd_updown_counter #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic        running,
  output logic        wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {btn_clear, btn_start};

  // Per button: 2-flop synchronizer, stable-time debouncer, rising-edge pulse.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          sync1_q, sync2_q, stable_q, stable_dly_q;
    logic [DW-1:0] db_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        db_cnt_q     <= '0;
      end else begin
        sync1_q      <= btn_raw[b];
        sync2_q      <= sync1_q;
        stable_dly_q <= stable_q;
        if (sync2_q != stable_q) begin
          if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= sync2_q;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_q <= '0;
        end
      end
    end

    assign press[b] = stable_q & ~stable_dly_q;
  end

  logic start_p, clear_p;
  assign start_p = press[0];
  assign clear_p = press[1];

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0][3:0] digit_q, digit_d;
  logic            running_q, wrap_q, wrap_d;
  logic            tick, carry;

  assign tick = (state_q == RUN) && (presc_q == PW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_p) state_d = RUN;
      RUN:     if (start_p) state_d = PAUSE;
      PAUSE:   if (start_p) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (clear_p) state_d = IDLE;
  end

  // Prescaler holds only in PAUSE; a load+start restart begins a fresh period.
  always_comb begin
    presc_d = presc_q;
    if (clear_p) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end else if (state_q != PAUSE || (load && start_p)) begin
      presc_d = '0;
    end
  end

  always_comb begin
    digit_d = digit_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    if (clear_p) begin
      digit_d = '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (up_down) begin
            if (digit_q[i] == 4'd9) digit_d[i] = 4'd0;
            else begin
              digit_d[i] = digit_q[i] + 4'd1;
              carry      = 1'b0;
            end
          end else begin
            if (digit_q[i] == 4'd0) digit_d[i] = 4'd9;
            else begin
              digit_d[i] = digit_q[i] - 4'd1;
              carry      = 1'b0;
            end
          end
        end
      end
      // A carry/borrow escaping the top digit is exactly the wrap condition.
      wrap_d = carry;
    end else if (load && (state_q == IDLE || state_q == PAUSE)) begin
      for (int i = 0; i < 4; i++) begin
        digit_d[i] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      digit_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  assign digit1  = digit_q[0];
  assign digit2  = digit_q[1];
  assign digit3  = digit_q[2];
  assign digit4  = digit_q[3];
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - directed self-checking bench for bcd_updown_counter
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start, btn_clear, up_down, load;
  logic [15:0] load_value;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic        running, wrap;

  int tests = 0;
  int fails = 0;

  bcd_updown_counter #(
    .CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .up_down(up_down), .load(load), .load_value(load_value),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lv;
    logic        ud;
    logic [15:0] exp_load;
    logic [15:0] exp_tick;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [0:11];

  function automatic logic [15:0] digits();
    return {digit4, digit3, digit2, digit1};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    // Load-only vectors (IDLE clamp), then load+run vectors with one tick.
    vecs[0]  = '{16'h1234, 1'b1, 16'h1234, 16'h0000, 1'b0};
    vecs[1]  = '{16'hA3F1, 1'b1, 16'h9391, 16'h0000, 1'b0};
    vecs[2]  = '{16'hFFFF, 1'b1, 16'h9999, 16'h0000, 1'b0};
    vecs[3]  = '{16'h5A0B, 1'b1, 16'h5909, 16'h0000, 1'b0};
    vecs[4]  = '{16'h0000, 1'b1, 16'h0000, 16'h0001, 1'b0};
    vecs[5]  = '{16'h0009, 1'b1, 16'h0009, 16'h0010, 1'b0};
    vecs[6]  = '{16'h0999, 1'b1, 16'h0999, 16'h1000, 1'b0};
    vecs[7]  = '{16'h9999, 1'b1, 16'h9999, 16'h0000, 1'b1};
    vecs[8]  = '{16'h0010, 1'b0, 16'h0010, 16'h0009, 1'b0};
    vecs[9]  = '{16'h1000, 1'b0, 16'h1000, 16'h0999, 1'b0};
    vecs[10] = '{16'h0000, 1'b0, 16'h0000, 16'h9999, 1'b1};
    vecs[11] = '{16'h4321, 1'b1, 16'h4321, 16'h4322, 1'b0};

    rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
    up_down = 1'b1; load = 1'b0; load_value = '0;
    cyc(3);
    chk("reset_digits", digits(), 16'h0000);
    chk("reset_running", running, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_reset_digits", digits(), 16'h0000);
    chk("post_reset_running", running, 1'b0);

    for (int i = 0; i < 4; i++) begin
      load = 1'b1; load_value = vecs[i].lv;
      cyc(1);
      load = 1'b0;
      chk($sformatf("idle_load[%0d]", i), digits(), vecs[i].exp_load);
    end

    for (int i = 4; i < 12; i++) begin
      up_down = vecs[i].ud; load = 1'b1; load_value = vecs[i].lv;
      cyc(1);
      load = 1'b0;
      chk($sformatf("v%0d_load", i), digits(), vecs[i].exp_load);
      btn_start = 1'b1;
      cyc(6);
      chk($sformatf("v%0d_not_yet_running", i), running, 1'b0);
      cyc(1);
      chk($sformatf("v%0d_running", i), running, 1'b1);
      cyc(9);
      chk($sformatf("v%0d_before_tick", i), digits(), vecs[i].exp_load);
      chk($sformatf("v%0d_wrap_before", i), wrap, 1'b0);
      cyc(1);
      chk($sformatf("v%0d_tick", i), digits(), vecs[i].exp_tick);
      chk($sformatf("v%0d_wrap", i), wrap, vecs[i].exp_wrap);
      cyc(1);
      chk($sformatf("v%0d_wrap_pulse_end", i), wrap, 1'b0);
      btn_start = 1'b0; btn_clear = 1'b1;
      cyc(7);
      chk($sformatf("v%0d_clear_running", i), running, 1'b0);
      chk($sformatf("v%0d_clear_digits", i), digits(), 16'h0000);
      btn_clear = 1'b0;
      cyc(8);
    end

    // Bounce 1-0-1 with 2-cycle gaps, latency from final rise.
    up_down = 1'b1;
    btn_start = 1'b1; cyc(2);
    btn_start = 1'b0; cyc(2);
    btn_start = 1'b1;
    cyc(6);
    chk("bounce_not_yet", running, 1'b0);
    cyc(1);
    chk("bounce_running", running, 1'b1);
    btn_start = 1'b0;
    cyc(10);
    chk("bounce_first_tick", digits(), 16'h0001);

    // Pause with prescaler at 7, resume: tick lands 3 cycles after RUN re-entry.
    btn_start = 1'b1;
    cyc(7);
    chk("pause_running", running, 1'b0);
    btn_start = 1'b0;
    cyc(20);
    chk("pause_hold_digits", digits(), 16'h0001);
    chk("pause_hold_running", running, 1'b0);
    btn_start = 1'b1;
    cyc(7);
    chk("resume_running", running, 1'b1);
    btn_start = 1'b0;
    cyc(2);
    chk("resume_before_tick", digits(), 16'h0001);
    cyc(1);
    chk("resume_tick", digits(), 16'h0002);

    load = 1'b1; load_value = 16'h5555;
    cyc(1);
    load = 1'b0;
    chk("load_ignored_in_run", digits(), 16'h0002);

    // Clear press arrives in the same cycle as a tick.
    cyc(2);
    btn_clear = 1'b1;
    cyc(7);
    chk("clear_tick_digits", digits(), 16'h0000);
    chk("clear_tick_wrap", wrap, 1'b0);
    chk("clear_tick_running", running, 1'b0);
    btn_clear = 1'b0;
    cyc(8);

    // Load together with a start press in IDLE.
    btn_start = 1'b1;
    cyc(6);
    load = 1'b1; load_value = 16'h0123;
    cyc(1);
    load = 1'b0;
    chk("ld_start_idle_running", running, 1'b1);
    chk("ld_start_idle_digits", digits(), 16'h0123);
    btn_start = 1'b0;
    cyc(9);
    chk("ld_start_idle_before_tick", digits(), 16'h0123);
    cyc(1);
    chk("ld_start_idle_tick", digits(), 16'h0124);

    btn_start = 1'b1;
    cyc(7);
    chk("pause2_running", running, 1'b0);
    btn_start = 1'b0; load = 1'b1; load_value = 16'hA3F1;
    cyc(1);
    load = 1'b0;
    chk("pause_load_clamp", digits(), 16'h9391);
    cyc(8);

    // Load together with a start press in PAUSE restarts the prescaler.
    btn_start = 1'b1;
    cyc(6);
    load = 1'b1; load_value = 16'h0050;
    cyc(1);
    load = 1'b0;
    chk("ld_start_pause_running", running, 1'b1);
    chk("ld_start_pause_digits", digits(), 16'h0050);
    btn_start = 1'b0;
    cyc(3);
    chk("ld_start_pause_no_early_tick", digits(), 16'h0050);
    cyc(6);
    chk("ld_start_pause_before_tick", digits(), 16'h0050);
    cyc(1);
    chk("ld_start_pause_tick", digits(), 16'h0051);

    // Reset mid-RUN and mid-debounce, with start held through reset.
    btn_clear = 1'b1;
    cyc(3);
    rst_n = 1'b0; btn_start = 1'b1;
    #1;
    chk("midrun_reset_digits", digits(), 16'h0000);
    chk("midrun_reset_running", running, 1'b0);
    chk("midrun_reset_wrap", wrap, 1'b0);
    cyc(2);
    btn_clear = 1'b0; rst_n = 1'b1;
    cyc(6);
    chk("held_not_yet", running, 1'b0);
    cyc(1);
    chk("held_running", running, 1'b1);
    cyc(9);
    chk("held_before_tick", digits(), 16'h0000);
    cyc(1);
    chk("held_tick", digits(), 16'h0001);
    cyc(15);
    chk("held_single_press", running, 1'b1);
    btn_start = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
